e203_ifu_bht: RTL and testbench

//  Branch history table with target buffer for conditional branches (bxx). Sits downstream of the EXU

---
 rtl/e203_ifu_bht_pkg.sv | 41 ++++
 rtl/e203_ifu_bht.sv | 174 +++++++++++++++++
 tb/tb_e203_ifu_bht.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_ifu_bht_pkg.sv
// ----------------------------------------------------------------------------
// e203_ifu_bht_pkg
// Shared sizing, entry layout and PC field helpers for the IFU branch history
// table. The table is indexed by the halfword PC bits so that RVC branches at
// adjacent halfwords land in different entries.
// ----------------------------------------------------------------------------
package e203_ifu_bht_pkg;

    localparam int BHT_ENTRIES = 16;
    localparam int INDEX_W     = 4;
    localparam int TAG_W       = 8;
    localparam int PC_SIZE     = 32;

    // Counter value after reset, and the weakly-taken value given to a
    // freshly allocated entry.
    localparam logic [1:0] CNT_RST   = 2'b01;
    localparam logic [1:0] CNT_ALLOC = 2'b10;

    typedef struct packed {
        logic               vld;
        logic [TAG_W-1:0]   tag;
        logic [1:0]         cnt;
        logic [PC_SIZE-1:0] target;
    } bht_entry_t;

    localparam bht_entry_t BHT_ENTRY_RST = '{
        vld:    1'b0,
        tag:    '0,
        cnt:    CNT_RST,
        target: '0
    };

    function automatic logic [INDEX_W-1:0] pc_idx(input logic [PC_SIZE-1:0] pc);
        return pc[INDEX_W:1];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_SIZE-1:0] pc);
        return pc[INDEX_W+TAG_W:INDEX_W+1];
    endfunction

endpackage

// File: rtl/e203_ifu_bht.sv
// ----------------------------------------------------------------------------
// e203_ifu_bht
// Branch history table with target buffer for conditional branches. Serves
// the fetch PC with a same-cycle prediction and learns from committed branch
// outcomes through a one-stage update pipeline (capture, then read-modify-
// write of the indexed entry).
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   ifu_bht_req_pc    fetch PC to predict
//   bht_prdt_hit      valid entry with matching tag
//   bht_prdt_taken    hit and counter in a taken state
//   bht_prdt_target   stored target, zero on a miss
//   bht_wb_vld        a conditional branch commits this cycle
//   bht_wb_mis        that branch caused a mispredict flush
//   bht_wb_prdt       predicted direction (cross-check only)
//   bht_wb_rslv       resolved direction
//   bht_wb_pc         branch PC
//   bht_wb_takenPC    flush PC, meaningful only with bht_wb_mis
//   bht_clr           invalidate all entries (fence.i)
//   bht_mis_cnt       saturating count of committed mispredicts
// ----------------------------------------------------------------------------
module e203_ifu_bht
    import e203_ifu_bht_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_SIZE-1:0] ifu_bht_req_pc,
    output logic               bht_prdt_hit,
    output logic               bht_prdt_taken,
    output logic [PC_SIZE-1:0] bht_prdt_target,
    input  logic               bht_wb_vld,
    input  logic               bht_wb_mis,
    input  logic               bht_wb_prdt,
    input  logic               bht_wb_rslv,
    input  logic [PC_SIZE-1:0] bht_wb_pc,
    input  logic [PC_SIZE-1:0] bht_wb_takenPC,
    input  logic               bht_clr,
    output logic [15:0]        bht_mis_cnt
);

    function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic inc);
        if (inc) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else     return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Update capture stage
    // ------------------------------------------------------------------
    logic               r_upd_vld;
    logic [INDEX_W-1:0] r_upd_idx;
    logic [TAG_W-1:0]   r_upd_tag;
    logic               r_upd_mis;
    logic               r_upd_rslv;
    logic [PC_SIZE-1:0] r_upd_tpc;
    logic [15:0]        r_mis_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_vld  <= 1'b0;
            r_upd_idx  <= '0;
            r_upd_tag  <= '0;
            r_upd_mis  <= 1'b0;
            r_upd_rslv <= 1'b0;
            r_upd_tpc  <= '0;
        end else begin
            r_upd_vld <= bht_wb_vld;
            if (bht_wb_vld) begin
                r_upd_idx  <= pc_idx(bht_wb_pc);
                r_upd_tag  <= pc_tag(bht_wb_pc);
                r_upd_mis  <= bht_wb_mis;
                r_upd_rslv <= bht_wb_rslv;
                r_upd_tpc  <= bht_wb_takenPC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mis_cnt <= '0;
        else if (bht_wb_vld && bht_wb_mis && (r_mis_cnt != 16'hFFFF))
            r_mis_cnt <= r_mis_cnt + 16'd1;
    end

    assign bht_mis_cnt = r_mis_cnt;

    // ------------------------------------------------------------------
    // Table storage and read-modify-write of the captured update
    // ------------------------------------------------------------------
    bht_entry_t [BHT_ENTRIES-1:0] w_table;
    bht_entry_t                   w_upd_cur;
    bht_entry_t                   w_upd_entry;
    logic                         w_upd_hit;
    logic                         w_alloc;
    logic                         w_hit_upd;
    logic                         w_upd_we;

    assign w_upd_cur = w_table[r_upd_idx];
    assign w_upd_hit = w_upd_cur.vld && (w_upd_cur.tag == r_upd_tag);
    assign w_hit_upd = r_upd_vld && w_upd_hit;
    assign w_alloc   = r_upd_vld && !w_upd_hit && r_upd_rslv && r_upd_mis;
    assign w_upd_we  = w_hit_upd || w_alloc;

    // NOTE: the entry is defaulted to its current value before any branch,
    // so every path assigns it and no latch is inferred.
    always_comb begin
        w_upd_entry = w_upd_cur;
        if (w_upd_hit) begin
            w_upd_entry.cnt = sat_cnt(w_upd_cur.cnt, r_upd_rslv);
            if (r_upd_rslv && r_upd_mis)
                w_upd_entry.target = r_upd_tpc;
        end else begin
            w_upd_entry.vld    = 1'b1;
            w_upd_entry.tag    = r_upd_tag;
            w_upd_entry.cnt    = CNT_ALLOC;
            w_upd_entry.target = r_upd_tpc;
        end
    end

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_entry
        bht_entry_t r_entry;

        // NOTE: the table is built from flops, not a RAM macro, so each
        // entry can be reset directly to a known state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_entry <= BHT_ENTRY_RST;
            else if (bht_clr)
                // Invalidate only; counters keep their history. A write
                // landing in the same cycle is dropped.
                r_entry.vld <= 1'b0;
            else if (w_upd_we && (r_upd_idx == INDEX_W'(g)))
                r_entry <= w_upd_entry;
        end

        assign w_table[g] = r_entry;
    end

    // ------------------------------------------------------------------
    // Lookup, with the in-flight write forwarded so a branch that just
    // committed is predicted correctly one cycle earlier.
    // ------------------------------------------------------------------
    logic [INDEX_W-1:0] w_req_idx;
    bht_entry_t         w_lkp;
    logic               w_lkp_hit;

    assign w_req_idx = pc_idx(ifu_bht_req_pc);
    assign w_lkp     = (w_upd_we && (w_req_idx == r_upd_idx)) ? w_upd_entry : w_table[w_req_idx];
    assign w_lkp_hit = w_lkp.vld && (w_lkp.tag == pc_tag(ifu_bht_req_pc));

    assign bht_prdt_hit    = w_lkp_hit;
    assign bht_prdt_taken  = w_lkp_hit && w_lkp.cnt[1];
    assign bht_prdt_target = w_lkp_hit ? w_lkp.target : '0;

    // PC bits outside the index/tag window do not take part in the lookup.
    logic w_unused_pc;
    assign w_unused_pc = ^{ifu_bht_req_pc[0], ifu_bht_req_pc[PC_SIZE-1:INDEX_W+TAG_W+1],
                           bht_wb_pc[0], bht_wb_pc[PC_SIZE-1:INDEX_W+TAG_W+1]};

    // ------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------
    ap_upd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({w_alloc, w_hit_upd}));

    ap_prdt_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({bht_prdt_hit, bht_prdt_taken, bht_prdt_target}));

    ap_mis_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        bht_wb_vld |-> (bht_wb_mis == (bht_wb_prdt != bht_wb_rslv)));

endmodule

// File: tb/tb_e203_ifu_bht.sv
// ----------------------------------------------------------------------------
// tb_e203_ifu_bht
// Directed and randomized stimulus for e203_ifu_bht, checked against a
// behavioural table model that applies each committed branch as a whole-entry
// rule and answers lookups from the latest committed view.
// ----------------------------------------------------------------------------
module tb_e203_ifu_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_pc;
    logic        prdt_hit;
    logic        prdt_taken;
    logic [31:0] prdt_target;
    logic        wb_vld;
    logic        wb_mis;
    logic        wb_prdt;
    logic        wb_rslv;
    logic [31:0] wb_pc;
    logic [31:0] wb_tpc;
    logic        clr;
    logic [15:0] mis_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    e203_ifu_bht dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifu_bht_req_pc  (req_pc),
        .bht_prdt_hit    (prdt_hit),
        .bht_prdt_taken  (prdt_taken),
        .bht_prdt_target (prdt_target),
        .bht_wb_vld      (wb_vld),
        .bht_wb_mis      (wb_mis),
        .bht_wb_prdt     (wb_prdt),
        .bht_wb_rslv     (wb_rslv),
        .bht_wb_pc       (wb_pc),
        .bht_wb_takenPC  (wb_tpc),
        .bht_clr         (clr),
        .bht_mis_cnt     (mis_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit          vld;
        int          tag;
        int          cnt;
        logic [31:0] tgt;
    } m_ent_t;

    m_ent_t      m_tab [16];
    bit          p_vld;
    logic [31:0] p_pc;
    logic [31:0] p_tpc;
    bit          p_rslv;
    bit          p_mis;
    int          m_mis;

    function automatic int f_idx(input logic [31:0] pc);
        return int'((pc >> 1) % 16);
    endfunction

    function automatic int f_tag(input logic [31:0] pc);
        return int'((pc >> 5) % 256);
    endfunction

    function automatic m_ent_t m_update(input m_ent_t e, input logic [31:0] pc,
                                        input bit rslv, input bit mis, input logic [31:0] tpc);
        m_ent_t n;
        n = e;
        if (e.vld && e.tag == f_tag(pc)) begin
            if (rslv) n.cnt = (e.cnt == 3) ? 3 : e.cnt + 1;
            else      n.cnt = (e.cnt == 0) ? 0 : e.cnt - 1;
            if (rslv && mis) n.tgt = tpc;
        end else if (rslv && mis) begin
            n.vld = 1'b1;
            n.tag = f_tag(pc);
            n.cnt = 2;
            n.tgt = tpc;
        end
        return n;
    endfunction

    // Returns {hit, taken, target} as seen from the committed history,
    // including the branch captured at the last edge.
    function automatic logic [33:0] m_predict(input logic [31:0] pc);
        m_ent_t e;
        bit     hit;
        e = m_tab[f_idx(pc)];
        if (p_vld && f_idx(p_pc) == f_idx(pc))
            e = m_update(e, p_pc, p_rslv, p_mis, p_tpc);
        hit = e.vld && (e.tag == f_tag(pc));
        return {hit, hit && (e.cnt >= 2), hit ? e.tgt : 32'h0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = '{vld: 1'b0, tag: 0, cnt: 1, tgt: 32'h0};
        p_vld = 1'b0;
        p_pc  = '0;
        p_tpc = '0;
        p_rslv = 1'b0;
        p_mis = 1'b0;
        m_mis = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (clr) begin
                for (int i = 0; i < 16; i++) m_tab[i].vld = 1'b0;
            end else if (p_vld) begin
                m_tab[f_idx(p_pc)] = m_update(m_tab[f_idx(p_pc)], p_pc, p_rslv, p_mis, p_tpc);
            end
            if (wb_vld && wb_mis && m_mis < 65535) m_mis++;
            p_vld  = wb_vld;
            p_pc   = wb_pc;
            p_tpc  = wb_tpc;
            p_rslv = wb_rslv;
            p_mis  = wb_mis;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change at the falling edge, outputs are
    // sampled 1ns after that.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wb(input logic [31:0] pc, input bit rslv, input logic [31:0] tpc, input bit do_clr);
        logic [33:0] p;
        p = m_predict(pc);
        wb_vld  = 1'b1;
        wb_pc   = pc;
        wb_rslv = rslv;
        wb_prdt = p[32];
        wb_mis  = (p[32] != rslv);
        wb_tpc  = tpc;
        clr     = do_clr;
        tick();
        wb_vld = 1'b0;
        wb_mis = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic check_lookup(input logic [31:0] pc, input string tag_s);
        logic [33:0] obs;
        logic [33:0] exp;
        req_pc = pc;
        #1;
        exp = m_predict(pc);
        obs = {prdt_hit, prdt_taken, prdt_target};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s pc=%h observed hit/taken/target=%b/%b/%h expected=%b/%b/%h",
                   tag_s, pc, obs[33], obs[32], obs[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic check_const(input logic [31:0] pc, input logic [33:0] exp, input string tag_s);
        logic [33:0] obs;
        req_pc = pc;
        #1;
        obs = {prdt_hit, prdt_taken, prdt_target};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s pc=%h observed=%h expected=%h", tag_s, pc, obs, exp);
        end
    endtask

    task automatic check_mis(input string tag_s);
        checks++;
        assert (mis_cnt === 16'(m_mis)) else begin
            errors++;
            $error("FAIL %s observed mis_cnt=%h expected=%h", tag_s, mis_cnt, 16'(m_mis));
        end
    endtask

    localparam logic [31:0] PC_A = 32'h8000_0010;
    localparam logic [31:0] PC_B = 32'h8000_0210;  // same index as PC_A, other tag
    localparam logic [31:0] PC_C = 32'h8000_0024;

    logic [31:0] pc_pool [6];

    initial begin
        pc_pool[0] = PC_A;
        pc_pool[1] = PC_B;
        pc_pool[2] = PC_C;
        pc_pool[3] = 32'h8000_1024;
        pc_pool[4] = 32'h8000_003E;
        pc_pool[5] = 32'h8000_0000;

        rst_n   = 1'b0;
        req_pc  = PC_A;
        wb_vld  = 1'b0;
        wb_mis  = 1'b0;
        wb_prdt = 1'b0;
        wb_rslv = 1'b0;
        wb_pc   = '0;
        wb_tpc  = '0;
        clr     = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Reset state: empty table, zero count.
        check_const(PC_A, 34'h0, "reset_lookup");
        check_mis("reset_mis_cnt");

        // First mispredicted taken branch allocates; visible via forwarding
        // in the very next cycle, then from the table.
        wb(PC_A, 1'b1, 32'h8000_0100, 1'b0);
        check_const(PC_A, {1'b1, 1'b1, 32'h8000_0100}, "alloc_forward");
        idle(1);
        check_const(PC_A, {1'b1, 1'b1, 32'h8000_0100}, "alloc_table");
        check_mis("alloc_mis_cnt");

        // Not-taken outcomes walk the counter down to its floor.
        wb(PC_A, 1'b0, 32'h0, 1'b0);
        check_const(PC_A, {1'b1, 1'b0, 32'h8000_0100}, "dec_2_to_1");
        for (int i = 0; i < 2; i++) begin
            wb(PC_A, 1'b0, 32'h0, 1'b0);
            check_lookup(PC_A, "dec_floor");
        end
        // Taken outcomes walk it up to saturation; the first ones mispredict
        // and refresh the target.
        for (int i = 0; i < 4; i++) begin
            wb(PC_A, 1'b1, 32'h8000_0200 + 32'(i * 4), 1'b0);
            check_lookup(PC_A, "inc_sat");
        end
        wb(PC_A, 1'b0, 32'h0, 1'b0);
        check_const(PC_A, {1'b1, 1'b1, 32'h8000_0204}, "sat_3_to_2");

        // Forwarding on another index.
        wb(PC_C, 1'b1, 32'h8000_0400, 1'b0);
        check_const(PC_C, {1'b1, 1'b1, 32'h8000_0400}, "forward_c");

        // Alias: not-taken miss writes nothing, taken miss reallocates.
        wb(PC_B, 1'b0, 32'h0, 1'b0);
        idle(1);
        check_lookup(PC_B, "alias_nowrite_b");
        check_lookup(PC_A, "alias_nowrite_a");
        wb(PC_B, 1'b1, 32'h8000_0800, 1'b0);
        idle(1);
        check_const(PC_B, {1'b1, 1'b1, 32'h8000_0800}, "alias_realloc_b");
        check_const(PC_A, 34'h0, "alias_evict_a");

        // Back-to-back updates to one entry chain without loss.
        wb(PC_A, 1'b1, 32'h8000_0A00, 1'b0);
        wb(PC_A, 1'b0, 32'h0, 1'b0);
        wb(PC_A, 1'b0, 32'h0, 1'b0);
        check_lookup(PC_A, "b2b_chain");
        idle(1);
        check_const(PC_A, {1'b1, 1'b0, 32'h8000_0A00}, "b2b_final");

        // Clear in the update-write cycle drops that write; a branch captured
        // alongside the clear still applies afterwards.
        wb(PC_C, 1'b0, 32'h0, 1'b0);
        wb(PC_B, 1'b0, 32'h0, 1'b1);
        check_const(PC_A, 34'h0, "clr_a");
        check_const(PC_C, 34'h0, "clr_c");
        check_const(PC_B, 34'h0, "clr_b");
        wb(PC_C, 1'b1, 32'h8000_0C00, 1'b0);
        wb(32'h8000_1024, 1'b1, 32'h8000_0E00, 1'b1);
        check_const(PC_C, 34'h0, "clr_drop_pending");
        check_const(32'h8000_1024, {1'b1, 1'b1, 32'h8000_0E00}, "clr_same_cycle_wb");
        check_mis("clr_mis_cnt");

        // Reset in the middle of an update drops it.
        wb(PC_A, 1'b1, 32'h8000_0F00, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_const(PC_A, 34'h0, "midreset_lookup");
        check_mis("midreset_mis_cnt");
        idle(1);
        rst_n = 1'b1;
        idle(1);
        check_const(PC_A, 34'h0, "post_reset_lookup");

        // Randomized traffic over a small aliasing PC pool.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                wb(pc_pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                   32'h8000_0000 | ($urandom & 32'h0000_FFFE), ($urandom_range(0, 15) == 0));
            else begin
                clr = ($urandom_range(0, 15) == 0);
                tick();
                clr = 1'b0;
            end
            check_lookup(pc_pool[$urandom_range(0, 5)], "random_lookup");
            if (i % 50 == 0) check_mis("random_mis_cnt");
        end
        check_mis("random_mis_cnt_end");

        // Mispredict counter saturation.
        for (int i = 0; i < 65540; i++) begin
            wb_vld  = 1'b1;
            wb_pc   = PC_C;
            wb_rslv = 1'b1;
            wb_prdt = 1'b0;
            wb_mis  = 1'b1;
            wb_tpc  = 32'h8000_1000;
            tick();
        end
        wb_vld = 1'b0;
        wb_mis = 1'b0;
        idle(2);
        check_mis("mis_cnt_saturate");
        checks++;
        assert (mis_cnt === 16'hFFFF) else begin
            errors++;
            $error("FAIL mis_cnt_hold observed=%h expected=ffff", mis_cnt);
        end
        check_lookup(PC_C, "after_saturation_lookup");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
